// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
//   Shared definitions for the microprogram control sequencer:
//   - STATE_W      : width of a microstore address
//   - ctrl_type_e  : next-address modes carried in a microword
//   - next_incr()  : modulo-2^STATE_W increment of a microstore address
package ctrl_seq_pkg;

  localparam int STATE_W = 7;

  typedef enum logic [2:0] {
    INCR     = 3'd0,
    JUMP     = 3'd1,
    DISPATCH = 3'd2,
    COND     = 3'd3,
    WAIT     = 3'd4,
    FETCH    = 3'd5
  } ctrl_type_e;

  // Sequential successor; the 7-bit result makes the top address wrap to zero.
  function automatic logic [STATE_W-1:0] next_incr(input logic [STATE_W-1:0] s);
    return s + 7'd1;
  endfunction

endpackage

// File: rtl/moc_timer.sv
// moc_timer
//   Counts consecutive WAIT cycles without memory-operation-complete and
//   flags the cycle on which the LIMIT-th such cycle occurs.
//   Parameters: LIMIT   - number of MOC-less WAIT cycles tolerated
//   Ports:      clk     - clock
//               reset   - synchronous active-high reset
//               active  - current microword is in WAIT mode
//               moc     - memory operation complete
//               expired - this cycle is the LIMIT-th without MOC (combinational)
module moc_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic moc,
  output logic expired
);

  logic [7:0] count;

  // count holds the number of earlier MOC-less WAIT cycles, so the current
  // cycle is number count+1; MOC in that same cycle suppresses the timeout.
  assign expired = active && !moc && (count == (LIMIT - 8'd1));

  // Wait counter: advances on MOC-less WAIT cycles, clears otherwise and on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (active && !moc && !expired) begin
      count <= count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microprogram next-address sequencer. Selects the next microstore address
//   from the current microword's Ctrl_Type and registers it as State.
//   Optional feature macro: MOC_TIMEOUT_EN enables the WAIT timeout
//   (moc_timer) that diverts to FAULT_STATE and pulses Mem_Fault.
//   Ports:
//     Clk, Reset              - clock and synchronous active-high reset
//     State_Sel [6:0]         - dispatch target (0 = unrecognised opcode)
//     Ctrl_Type [2:0]         - next-address mode
//     Ctrl_Target [6:0]       - jump/branch target
//     Ctrl_Inv, Cond          - branch condition and its inversion
//     MOC                     - memory operation complete
//     State [6:0]             - current microstore address (registered)
//     Stall                   - WAIT without MOC (combinational)
//     Illegal, Mem_Fault      - registered one-cycle event pulses
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter logic [STATE_W-1:0] FETCH_STATE = 7'd0,
  parameter logic [STATE_W-1:0] FAULT_STATE = 7'd127,
  parameter logic [7:0]         MOC_LIMIT   = 8'd255
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic [2:0]         Ctrl_Type,
  input  logic [STATE_W-1:0] Ctrl_Target,
  input  logic               Ctrl_Inv,
  input  logic               Cond,
  input  logic               MOC,
  output logic [STATE_W-1:0] State,
  output logic               Stall,
  output logic               Illegal,
  output logic               Mem_Fault
);

  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] incr_state;
  logic               illegal_next;
  logic               wait_active;
  logic               timeout;

  assign incr_state  = next_incr(State);
  assign wait_active = (Ctrl_Type == WAIT);
  assign Stall       = wait_active && !MOC;

`ifdef MOC_TIMEOUT_EN
  moc_timer #(
    .LIMIT (MOC_LIMIT)
  ) u_moc_timer (
    .clk     (Clk),
    .reset   (Reset),
    .active  (wait_active),
    .moc     (MOC),
    .expired (timeout)
  );

  // Timeout event register: one pulse per expiry, the timer clears itself.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Mem_Fault <= 1'b0;
    end else begin
      Mem_Fault <= timeout;
    end
  end
`else
  assign timeout   = 1'b0;
  assign Mem_Fault = 1'b0;
`endif

  // Next-address selection from the current microword mode.
  always_comb begin
    next_state   = FETCH_STATE;
    illegal_next = 1'b0;
    case (Ctrl_Type)
      INCR:     next_state = incr_state;
      JUMP:     next_state = Ctrl_Target;
      DISPATCH: begin
        if (State_Sel == 7'd0) begin
          next_state   = FETCH_STATE;
          illegal_next = 1'b1;
        end else begin
          next_state   = State_Sel;
          illegal_next = 1'b0;
        end
      end
      COND: begin
        if (Cond ^ Ctrl_Inv) begin
          next_state = Ctrl_Target;
        end else begin
          next_state = incr_state;
        end
      end
      WAIT: begin
        // MOC takes priority over a timeout in the same cycle.
        if (MOC) begin
          next_state = incr_state;
        end else if (timeout) begin
          next_state = FAULT_STATE;
        end else begin
          next_state = State;
        end
      end
      FETCH:    next_state = FETCH_STATE;
      default:  next_state = FETCH_STATE;
    endcase
  end

  // State and illegal-opcode registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      State   <= FETCH_STATE;
      Illegal <= 1'b0;
    end else begin
      State   <= next_state;
      Illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer. Each step drives one microword,
//   checks the combinational Stall in that cycle, pushes the expected
//   registered outputs to a scoreboard queue and pops/compares them after the
//   next rising edge. MOC_TIMEOUT_EN selects the expected timeout behaviour.
module tb_control_sequencer;

  logic       Clk;
  logic       Reset;
  logic [6:0] State_Sel;
  logic [2:0] Ctrl_Type;
  logic [6:0] Ctrl_Target;
  logic       Ctrl_Inv;
  logic       Cond;
  logic       MOC;
  logic [6:0] State;
  logic       Stall;
  logic       Illegal;
  logic       Mem_Fault;

  typedef struct {
    logic [6:0] state;
    logic       illegal;
    logic       fault;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  control_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .State_Sel   (State_Sel),
    .Ctrl_Type   (Ctrl_Type),
    .Ctrl_Target (Ctrl_Target),
    .Ctrl_Inv    (Ctrl_Inv),
    .Cond        (Cond),
    .MOC         (MOC),
    .State       (State),
    .Stall       (Stall),
    .Illegal     (Illegal),
    .Mem_Fault   (Mem_Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock of stimulus: check Stall now, registered outputs after the edge.
  task automatic step(input logic rst, input logic [2:0] ct, input logic [6:0] tgt,
                      input logic [6:0] sel, input logic cnd, input logic inv,
                      input logic moc, input logic exp_stall, input logic [6:0] exp_state,
                      input logic exp_ill, input logic exp_flt, input string name);
    exp_t e;
    exp_t got;
    Reset = rst; Ctrl_Type = ct; Ctrl_Target = tgt; State_Sel = sel;
    Cond = cnd; Ctrl_Inv = inv; MOC = moc;
    #1;
    checks++;
    if (Stall !== exp_stall) begin
      errors++;
      $display("FAIL %s stall got %b want %b", name, Stall, exp_stall);
    end
    e.state = exp_state; e.illegal = exp_ill; e.fault = exp_flt; e.name = name;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got 0 want 1", name);
    end else begin
      got = sb.pop_front();
      if (State !== got.state) begin
        errors++;
        $display("FAIL %s state got %0d want %0d", got.name, State, got.state);
      end
      checks++;
      if (Illegal !== got.illegal) begin
        errors++;
        $display("FAIL %s illegal got %b want %b", got.name, Illegal, got.illegal);
      end
      checks++;
      if (Mem_Fault !== got.fault) begin
        errors++;
        $display("FAIL %s mem_fault got %b want %b", got.name, Mem_Fault, got.fault);
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "reset_init");
    step(1'b1, 3'd1, 7'd99, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "reset_hold");
    step(1'b0, 3'd1, 7'd45, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd45, 1'b0, 1'b0, "reset_jump45");
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd45, 1'b0, 1'b0, "reset_wait45");
    step(1'b1, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, "reset_midwait");
  endtask

  task automatic test_dispatch();
    step(1'b0, 3'd2, 7'd0, 7'd18, 1'b0, 1'b0, 1'b0, 1'b0, 7'd18, 1'b0, 1'b0, "dispatch18");
    step(1'b0, 3'd2, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, "dispatch_illegal");
    step(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, "illegal_one_cycle");
  endtask

  task automatic test_branch();
    step(1'b0, 3'd1, 7'd11, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd11, 1'b0, 1'b0, "jump11");
    step(1'b0, 3'd3, 7'd40, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd40, 1'b0, 1'b0, "cond_taken");
    step(1'b0, 3'd1, 7'd11, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd11, 1'b0, 1'b0, "jump11b");
    step(1'b0, 3'd3, 7'd40, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd12, 1'b0, 1'b0, "cond_inv_fall");
    step(1'b0, 3'd3, 7'd40, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd40, 1'b0, 1'b0, "cond_inv_taken");
    step(1'b0, 3'd3, 7'd90, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd41, 1'b0, 1'b0, "cond_fall");
  endtask

  task automatic test_wait();
    step(1'b0, 3'd1, 7'd13, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd13, 1'b0, 1'b0, "jump13");
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd13, 1'b0, 1'b0, "wait_stall");
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd14, 1'b0, 1'b0, "wait_moc");
  endtask

  task automatic test_wrap_fetch();
    step(1'b0, 3'd1, 7'd127, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 1'b0, 1'b0, "jump127");
    step(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "incr_wrap");
    for (int t = 5; t <= 7; t++) begin
      step(1'b0, 3'd1, 7'd77, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd77, 1'b0, 1'b0, "jump77");
      step(1'b0, 3'(t), 7'd33, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "fetch_type");
    end
  endtask

  task automatic test_timeout();
    // MOC never arrives: the 255th MOC-less WAIT cycle is the timeout.
    step(1'b0, 3'd1, 7'd50, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd50, 1'b0, 1'b0, "jump50");
    for (int i = 1; i <= 254; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd50, 1'b0, 1'b0, "timeout_pre");
`ifdef MOC_TIMEOUT_EN
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 1'b0, 1'b1, "timeout_hit");
    step(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "fault_one_cycle");
`else
    for (int i = 0; i < 40; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd50, 1'b0, 1'b0, "wait_forever");
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd51, 1'b0, 1'b0, "wait_forever_moc");
`endif
    // MOC arrives in the limit cycle: MOC wins.
    step(1'b0, 3'd1, 7'd60, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1'b0, 1'b0, "jump60");
    for (int i = 1; i <= 254; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd60, 1'b0, 1'b0, "moc_race_pre");
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd61, 1'b0, 1'b0, "moc_race_win");
    // Reset mid-WAIT clears the counter: a fresh 254-cycle wait must not fault.
    step(1'b0, 3'd1, 7'd70, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd70, 1'b0, 1'b0, "jump70");
    for (int i = 1; i <= 200; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd70, 1'b0, 1'b0, "prereset_wait");
    step(1'b1, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, "reset_in_wait");
    for (int i = 1; i <= 254; i++)
      step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, "postreset_wait");
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, "postreset_moc");
  endtask

  task automatic test_back_to_back();
    step(1'b0, 3'd2, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, "b2b_illegal_a");
    step(1'b0, 3'd2, 7'd0, 7'd25, 1'b0, 1'b0, 1'b0, 1'b0, 7'd25, 1'b0, 1'b0, "b2b_dispatch25");
    step(1'b0, 3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd26, 1'b0, 1'b0, "b2b_wait_moc");
    step(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd27, 1'b0, 1'b0, "b2b_incr");
  endtask

  initial begin
    Reset = 1'b1; Ctrl_Type = 3'd0; Ctrl_Target = 7'd0; State_Sel = 7'd0;
    Cond = 1'b0; Ctrl_Inv = 1'b0; MOC = 1'b0;
    test_reset();
    test_dispatch();
    test_branch();
    test_wait();
    test_wrap_fetch();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter FETCH_STATE, default 7'd0: microstore address of the instruction-fetch state, and the reset target.
REQ-002 Parameter FAULT_STATE, default 7'd127: microstore address entered on memory timeout.
REQ-003 Parameter MOC_LIMIT, default 8'd255: cycles waited for MOC before a fault is raised.
REQ-004 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port State_Sel, input, 7 bits: dispatch target from the instruction state encoder; 7'd0 means unrecognised opcode.
REQ-007 Port Ctrl_Type, input, 3 bits: next-address mode from the current microword.
REQ-008 Port Ctrl_Target, input, 7 bits: jump/branch target from the current microword.
REQ-009 Port Ctrl_Inv, input, 1 bit: inverts Cond for COND mode.
REQ-010 Port Cond, input, 1 bit: datapath branch condition.
REQ-011 Port MOC, input, 1 bit: memory operation complete.
REQ-012 Port State, output, 7 bits: current microstore address (registered).
REQ-013 Port Stall, output, 1 bit: combinational; high when Ctrl_Type==WAIT and MOC==0.
REQ-014 Port Illegal, output, 1 bit: registered one-cycle pulse on dispatch of an unrecognised opcode.
REQ-015 Port Mem_Fault, output, 1 bit: registered one-cycle pulse on MOC timeout.

Function
REQ-016 The next State SHALL be selected per Ctrl_Type: 0 INCR -> State+1; 1 JUMP -> Ctrl_Target; 2 DISPATCH -> State_Sel; 3 COND -> (Cond^Ctrl_Inv) ? Ctrl_Target : State+1; 4 WAIT -> hold until MOC, then State+1; 5 FETCH -> FETCH_STATE; 6/7 -> FETCH_STATE.
REQ-017 State+1 SHALL be 7-bit modulo arithmetic, so 7'd127 wraps to 7'd0.
REQ-018 State SHALL update one clock after Ctrl_Type/inputs are sampled; there SHALL be no other latency.
REQ-019 DISPATCH with State_Sel==7'd0 SHALL load FETCH_STATE and assert Illegal for exactly the next cycle.
REQ-020 In WAIT, an internal 8-bit wait counter SHALL increment each cycle MOC==0 and clear on leaving WAIT or on MOC==1.
REQ-021 If MOC==1 in the same cycle the counter reaches MOC_LIMIT, MOC SHALL win: advance to State+1, no fault.
REQ-022 Illegal and Mem_Fault SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-023 On Reset==1 at a clock edge, State SHALL become FETCH_STATE, Illegal and Mem_Fault SHALL become 0, and the wait counter SHALL become 0.
REQ-024 Reset SHALL override every Ctrl_Type, including mid-WAIT, with no fault raised.

Configuration
REQ-025 With MOC_TIMEOUT_EN defined, a WAIT reaching MOC_LIMIT cycles without MOC SHALL load FAULT_STATE and pulse Mem_Fault for one cycle.
REQ-026 Without MOC_TIMEOUT_EN, WAIT SHALL hold indefinitely, Mem_Fault SHALL be constant 0, and the counter SHALL be removed.

Structure
REQ-027 A shared package ctrl_seq_pkg SHALL hold the Ctrl_Type encodings (INCR, JUMP, DISPATCH, COND, WAIT, FETCH) and the 7-bit state-address width constant.
REQ-028 The wait counter and limit compare SHALL be a sub-module moc_timer, instantiated only under MOC_TIMEOUT_EN.

Verification
REQ-029 Reset test: after Reset for 1 cycle with State=7'd45 in WAIT -> State=7'd0, Illegal=0, Mem_Fault=0.
REQ-030 Dispatch test: Ctrl_Type=2, State_Sel=7'd18 -> next State=7'd18, Illegal=0; State_Sel=7'd0 -> State=7'd0, Illegal=1 for one cycle.
REQ-031 Branch test: Ctrl_Type=3, Ctrl_Target=7'd40, State=7'd11, Cond=1, Ctrl_Inv=0 -> State=7'd40; Ctrl_Inv=1 -> State=7'd12.
REQ-032 Wait test: Ctrl_Type=4 at State=7'd13, MOC low 3 cycles then high -> Stall=1 for 3 cycles, State=7'd14 the cycle after MOC.
REQ-033 Timeout test (MOC_TIMEOUT_EN): MOC held 0 in WAIT -> State=7'd127 and one-cycle Mem_Fault after 255 cycles; MOC=1 on cycle 255 -> State+1, no fault.
REQ-034 Wrap test: Ctrl_Type=0 at State=7'd127 -> State=7'd0.
